// File: rtl/snn_pkg.sv
// snn_pkg: shared state type and index-width helper for the SNN run controller.
package snn_pkg;

    // Run controller states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        SCAN   = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } run_state_t;

    // Default timestep counter width.
    localparam int STEP_W_DEF = 8;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_idx_counter.sv
// snn_idx_counter: index counter that wraps to zero after LIMIT-1 and flags
// the terminal value. Used for both neuron and layer indices.
module snn_idx_counter #(
    parameter int LIMIT = 2,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    assign tc = (count == LAST);

    // Advance on inc; a terminal-value compare wraps back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/snn_run_ctrl.sv
// snn_run_ctrl: run controller for the SNN core. A start_en rising edge in
// IDLE clears membrane state, then sweeps layers x neurons for the latched
// number of timesteps, one neuron-update request per valid/ready handshake.
// Optional build macro SNN_RUN_CTRL_PERF_EN adds a 32-bit saturating
// stall_cnt output (cycles with nrn_valid high and nrn_ready low).
module snn_run_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_LAYERS        = 2,
    parameter int NEURONS_PER_LAYER = 64,
    parameter int STEP_W            = STEP_W_DEF,
    parameter int LAYER_W           = idx_width(NUM_LAYERS),
    parameter int NRN_W             = idx_width(NEURONS_PER_LAYER)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_en,
    input  logic               abort,
    input  logic [STEP_W-1:0]  num_steps,
    output logic               nrn_valid,
    input  logic               nrn_ready,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [NRN_W-1:0]   neuron_idx,
    output logic [STEP_W-1:0]  step_idx,
    output logic               mem_clr,
    output logic               step_commit,
    output logic               busy,
    output logic               done
`ifdef SNN_RUN_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    run_state_t        state;
    logic              start_prev;
    logic [STEP_W-1:0] steps_q;

    logic start_fire;
    logic abort_fire;
    logic hs;
    logic layer_inc;
    logic idx_clear;
    logic neuron_tc;
    logic layer_tc;
    logic step_last;

    assign start_fire = start_en && !start_prev && (state == IDLE);
    assign abort_fire = abort && (state != IDLE);
    // Abort wins over a simultaneous handshake, so the index does not move.
    assign hs         = nrn_valid && nrn_ready && !abort;
    assign layer_inc  = hs && neuron_tc;
    assign idx_clear  = (state == CLR) || abort_fire;
    assign step_last  = (step_idx == steps_q - 1'b1);

    snn_idx_counter #(
        .LIMIT (NEURONS_PER_LAYER),
        .W     (NRN_W)
    ) u_neuron_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (idx_clear),
        .inc   (hs),
        .count (neuron_idx),
        .tc    (neuron_tc)
    );

    snn_idx_counter #(
        .LIMIT (NUM_LAYERS),
        .W     (LAYER_W)
    ) u_layer_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (idx_clear),
        .inc   (layer_inc),
        .count (layer_idx),
        .tc    (layer_tc)
    );

    // Run sequencing FSM with registered outputs and the start edge register.
    // NOTE: every register here uses <= so all branches see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            start_prev  <= 1'b0;
            steps_q     <= '0;
            step_idx    <= '0;
            nrn_valid   <= 1'b0;
            mem_clr     <= 1'b0;
            step_commit <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_prev  <= start_en;
            mem_clr     <= 1'b0;
            step_commit <= 1'b0;
            done        <= 1'b0;
            if (abort_fire) begin
                state     <= IDLE;
                nrn_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_fire) begin
                            steps_q <= num_steps;
                            state   <= CLR;
                            mem_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    CLR: begin
                        step_idx <= '0;
                        if (steps_q == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= SCAN;
                            nrn_valid <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (hs && neuron_tc && layer_tc) begin
                            state       <= COMMIT;
                            nrn_valid   <= 1'b0;
                            step_commit <= 1'b1;
                        end
                    end
                    COMMIT: begin
                        if (step_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            step_idx  <= step_idx + 1'b1;
                            state     <= SCAN;
                            nrn_valid <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        nrn_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SNN_RUN_CTRL_PERF_EN
    // Count cycles the datapath leaves a request waiting; saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == CLR) begin
            stall_cnt <= '0;
        end else if (nrn_valid && !nrn_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snn_run_ctrl.sv
// tb_snn_run_ctrl: scoreboard bench for snn_run_ctrl. The driver walks the
// run schedule (steps x layers x neurons) and queues the expected events;
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_snn_run_ctrl;

    localparam int L  = 2;
    localparam int N  = 4;
    localparam int LN = L * N;
    localparam int SW = 8;
    localparam int LW = (L > 1) ? $clog2(L) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    localparam int EV_CLR    = 1;
    localparam int EV_HS     = 2;
    localparam int EV_COMMIT = 3;
    localparam int EV_DONE   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_en = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] num_steps = '0;
    logic          nrn_valid;
    logic          nrn_ready = 1'b0;
    logic [LW-1:0] layer_idx;
    logic [NW-1:0] neuron_idx;
    logic [SW-1:0] step_idx;
    logic          mem_clr;
    logic          step_commit;
    logic          busy;
    logic          done;
`ifdef SNN_RUN_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp_stall = 0;
    int busy_cnt = 0;

    snn_run_ctrl #(
        .NUM_LAYERS        (L),
        .NEURONS_PER_LAYER (N),
        .STEP_W            (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_en    (start_en),
        .abort       (abort),
        .num_steps   (num_steps),
        .nrn_valid   (nrn_valid),
        .nrn_ready   (nrn_ready),
        .layer_idx   (layer_idx),
        .neuron_idx  (neuron_idx),
        .step_idx    (step_idx),
        .mem_clr     (mem_clr),
        .step_commit (step_commit),
        .busy        (busy),
        .done        (done)
`ifdef SNN_RUN_CTRL_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int enc(input int k, input int s, input int l, input int n);
        return (k << 24) | (s << 16) | (l << 8) | n;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, nrn_valid, 0);
        check({tag, "_mem_clr"}, mem_clr, 0);
        check({tag, "_commit"}, step_commit, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_layer"}, layer_idx, 0);
        check({tag, "_neuron"}, neuron_idx, 0);
        check({tag, "_step"}, step_idx, 0);
`ifdef SNN_RUN_CTRL_PERF_EN
        check({tag, "_stall"}, stall_cnt, 0);
`endif
    endtask

    // Monitor: every event the DUT presents must match the queue head.
    always @(negedge clk) begin
        int act;
        bit have;
        if (!reset) begin
            if (busy) busy_cnt++;
            have = 1'b0;
            act  = 0;
            if (mem_clr) begin
                act = enc(EV_CLR, 0, 0, 0); have = 1'b1;
            end else if (nrn_valid && nrn_ready && !abort) begin
                act = enc(EV_HS, int'(step_idx), int'(layer_idx), int'(neuron_idx)); have = 1'b1;
            end else if (step_commit) begin
                act = enc(EV_COMMIT, int'(step_idx), 0, 0); have = 1'b1;
            end else if (done) begin
                act = enc(EV_DONE, int'(step_idx), 0, 0); have = 1'b1;
            end
            if (have) begin
                if (exp_q.size() == 0) check("unexpected_event", act, 0);
                else check("event", act, exp_q.pop_front());
            end
        end
    end

    // One run: rnd randomises ready, abort_at aborts at that request index,
    // rst_commit resets asynchronously in the first COMMIT, hold keeps start_en high.
    task automatic run(input int steps, input bit rnd, input int abort_at,
                       input bit rst_commit, input bit hold);
        int  s, l, n;
        bit  r;
        exp_stall = 0;
        busy_cnt  = 0;
        exp_q.push_back(enc(EV_CLR, 0, 0, 0));
        num_steps = SW'(steps);
        start_en  = 1'b1;
        tick();                                  // CLR visible
        if (!hold) start_en = 1'b0;
        num_steps = SW'($urandom);               // latched copy must be used
        if (steps == 0) begin
            exp_q.push_back(enc(EV_DONE, 0, 0, 0));
            tick();                              // DONE visible
            tick();                              // IDLE visible
            check("zero_busy_cycles", busy_cnt, 2);
            check("zero_busy_end", busy, 0);
            return;
        end
        for (int h = 0; h < steps * LN; h++) begin
            s = h / LN;
            l = (h / N) % L;
            n = h % N;
            tick();                              // request h visible
            if (!hold) start_en = rnd && (h == 3);
            if (h == abort_at) begin
                abort     = 1'b1;
                nrn_ready = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_valid", nrn_valid, 0);
`ifdef SNN_RUN_CTRL_PERF_EN
                check("abort_stall_hold", stall_cnt, exp_stall);
`endif
                repeat (3) tick();
                check("abort_idle", busy, 0);
                return;
            end
            exp_q.push_back(enc(EV_HS, s, l, n));
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!r) begin
                nrn_ready = 1'b0;
                exp_stall++;
                tick();
                r = 1'($urandom_range(0, 1));
            end
            nrn_ready = 1'b1;
            if ((h + 1) % LN == 0) begin
                tick();                          // COMMIT visible
                if (!hold) start_en = 1'b0;
                if (rst_commit) begin
                    #1 reset = 1'b1;
                    #1;
                    exp_q.delete();
                    check_zero("reset_mid");
                    tick();
                    tick();
                    reset = 1'b0;
                    repeat (5) tick();
                    check_zero("after_reset");
                    return;
                end
                exp_q.push_back(enc(EV_COMMIT, s, 0, 0));
                nrn_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        exp_q.push_back(enc(EV_DONE, steps - 1, 0, 0));
        tick();                                  // DONE visible
        tick();                                  // IDLE visible
        check("run_busy_cycles", busy_cnt, 2 + steps * (LN + 1) + exp_stall);
        check("run_end_busy", busy, 0);
`ifdef SNN_RUN_CTRL_PERF_EN
        check("run_stall_cnt", stall_cnt, exp_stall);
        tick();
        check("stall_hold_after_done", stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("post_reset");

        run(3, 1'b0, -1, 1'b0, 1'b0);            // ready high, 29 busy cycles
        run(3, 1'b1, -1, 1'b0, 1'b0);            // ready random, stalls counted
        run(0, 1'b0, -1, 1'b0, 1'b0);            // CLR then DONE only

        abort = 1'b1;                            // abort in IDLE is ignored
        tick();
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        run(2, 1'b1, 6, 1'b0, 1'b0);             // abort at layer 1, neuron 2
        run(1, 1'b0, -1, 1'b0, 1'b0);            // restart from zero indices

        run(1, 1'b0, -1, 1'b0, 1'b1);            // start held across the run
        repeat (8) tick();
        start_en = 1'b0;
        tick();
        run(1, 1'b0, -1, 1'b0, 1'b0);            // drop then rise: second run

        run(2, 1'b0, -1, 1'b1, 1'b0);            // async reset in COMMIT
        run(1, 1'b1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run($urandom_range(0, 3), 1'b1, -1, 1'b0, 1'b0);
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/snn_run_ctrl.md
Name: snn_run_ctrl

Overview:
Parametrised run controller for the SNN core; successor to the fixed single-shot start_en sequencing at top level.
- Accepts a start request and clears membrane state.
- Sweeps layers × neurons for a runtime-programmable number of timesteps, issuing one neuron-update request per valid/ready handshake.
- Pulses commit and done markers.
- Sits between the top-level control interface and the neuron/synapse datapath.

Parameters:
NUM_LAYERS, 2, number of layers swept per timestep (>=1)
NEURONS_PER_LAYER, 64, neurons updated per layer (>=1)
STEP_W, 8, width of the timestep count/index
LAYER_W, $clog2(NUM_LAYERS) min 1, width of layer index
NRN_W, $clog2(NEURONS_PER_LAYER) min 1, width of neuron index

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
start_en  in  1  run request, level; rising edge in IDLE starts a run
abort  in  1  synchronous abort, highest priority after reset
num_steps  in  STEP_W  timesteps per run, sampled at start
nrn_valid  out  1  neuron-update request valid
nrn_ready  in  1  datapath accepts request
layer_idx  out  LAYER_W  layer of current request
neuron_idx  out  NRN_W  neuron of current request
step_idx  out  STEP_W  current timestep
mem_clr  out  1  one-cycle membrane clear pulse
step_commit  out  1  one-cycle pulse after last neuron of last layer of a step
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset values: state IDLE; all outputs 0; indices 0; start edge register 0.
- start_en edge detect uses a registered copy. Start fires when start_en=1, prev=0, state=IDLE.
- A start_en held high across done does not restart; it must drop first.
- States and transitions:
  - IDLE: on start, latch num_steps into steps_q and go to CLR.
  - CLR: mem_clr=1 for exactly one cycle. Next state: DONE if steps_q==0, else SCAN with all indices 0.
  - SCAN: nrn_valid=1 and indices stable while nrn_ready=0. On handshake (valid&ready):
    - neuron_idx increments.
    - At NEURONS_PER_LAYER-1, neuron_idx wraps to 0 and layer_idx increments.
    - At last layer, layer_idx wraps to 0 and state goes to COMMIT.
  - COMMIT: step_commit=1 for one cycle, nrn_valid=0. If step_idx==steps_q-1 go to DONE; else step_idx++ and return to SCAN.
  - DONE: done=1 for one cycle, then IDLE. step_idx holds final value until next start, which clears it in CLR.
- Latency: start edge to first nrn_valid = 2 cycles (CLR, then SCAN).
- Minimum cycles per step with ready tied high = NUM_LAYERS*NEURONS_PER_LAYER + 1.
- Abort in any non-IDLE state: next cycle IDLE, nrn_valid=0, no done, no commit. Abort in IDLE is ignored. Abort beats a simultaneous handshake: the index is not advanced.
- start_en edge while busy: ignored, not queued.
- Async reset mid-run: immediate return to reset values.
- num_steps changes mid-run have no effect; the latched copy is used.
- num_steps=0: CLR then DONE. No nrn_valid, no commit.
- Counter arithmetic is unsigned. Indices never exceed their parameter limits; terminal-value compares are used, not overflow.

Optional Feature:
Macro SNN_RUN_CTRL_PERF_EN.
- Defined: adds output stall_cnt (32 bits). It counts cycles with nrn_valid=1 and nrn_ready=0. It clears at CLR, saturates at all-ones, and holds after DONE or abort.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package snn_pkg: state enum (IDLE, CLR, SCAN, COMMIT, DONE) and width helper constants.
- Sub-module snn_idx_counter: wrap counter with inc, terminal-count output, clear and parameter LIMIT. Instantiated twice, for neuron and layer indices.
- The step counter is inline because its limit comes from a runtime input.

Test Plan:
- NUM_LAYERS=2, NEURONS_PER_LAYER=4, num_steps=3, ready=1, start_en pulse: mem_clr at cycle+1, 8 handshakes per step, 3 step_commit pulses, done once, total 1+3*9+1 cycles.
- Same configuration with nrn_ready toggling every cycle: indices hold while ready=0, sequence unchanged, and stall_cnt equals the number of ready-low valid cycles (PERF_EN build).
- num_steps=0: mem_clr then done on the next cycle, no nrn_valid, busy high for exactly 2 cycles.
- Abort asserted mid-SCAN at layer 1, neuron 2: next cycle IDLE with busy=0, no done. A new start edge restarts from step 0, layer 0, neuron 0.
- start_en held high for 20 cycles spanning the whole run: exactly one run. A drop then rise starts a second run.
- Async reset asserted mid-COMMIT: all outputs 0 immediately. After release, the block stays IDLE until a fresh start edge.
